// File: rtl/ea_sequencer_pkg.sv
// Shared definitions for the PDP-8 effective-address sequencer: opcodes,
// IR field positions and the sequencer state encoding.
package ea_sequencer_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    localparam int OPC_MSB  = 11;
    localparam int OPC_LSB  = 9;
    localparam int IND_BIT  = 8;
    localparam int PAGE_BIT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IRD  = 2'd1,
        AIW  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Memory-reference instructions are every opcode up to and including JMP.
    function automatic logic is_mri(input logic [2:0] opc);
        return opc <= OP_JMP;
    endfunction

endpackage

// File: rtl/ea_sequencer_ea_calc.sv
// Combinational direct-address formation and auto-index range detection,
// using the same IR field split as the instruction decoder.
module ea_calc
    import ea_sequencer_pkg::*;
#(
    parameter logic [11:0] AUTOIDX_LO = 12'o0010,
    parameter logic [11:0] AUTOIDX_HI = 12'o0017
) (
    input  logic [11:0] ir,
    input  logic [11:0] pc,
    output logic [11:0] da,
    output logic        mri,
    output logic        ind,
    output logic        autoidx
);

    logic unused_pc_offset;

    always_comb begin
        mri     = is_mri(ir[OPC_MSB:OPC_LSB]);
        ind     = ir[IND_BIT];
        da      = ir[PAGE_BIT] ? {pc[11:7], ir[6:0]} : {5'b0, ir[6:0]};
        // Decided on the formed address, so a current-page reference from page 0 can auto-index.
        autoidx = (da >= AUTOIDX_LO) && (da <= AUTOIDX_HI);
    end

    // Only the page number of the PC takes part in address formation.
    assign unused_pc_offset = ^pc[6:0];

endmodule

// File: rtl/ea_sequencer.sv
// Resolves the operand address of a PDP-8 MRI, including the indirect read
// and the auto-index read-modify-write, over the shared memory port.
//
// state | meaning
// IDLE  | waiting for START
// IRD   | reading the indirect pointer at DA
// AIW   | writing the incremented pointer back to DA
// FIN   | DONE pulse, EA/EA_VALID just updated
module ea_sequencer
    import ea_sequencer_pkg::*;
#(
    parameter logic [11:0] AUTOIDX_LO = 12'o0010,
    parameter logic [11:0] AUTOIDX_HI = 12'o0017
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [11:0] IR,
    input  logic [11:0] PCLATCHED,
    output logic [11:0] MADDR,
    output logic        MRD,
    output logic        MWR,
    output logic [11:0] MWDATA,
    input  logic [11:0] MRDATA,
    input  logic        MACK,
    output logic [11:0] EA,
    output logic        EA_VALID,
    output logic        DONE,
    output logic        BUSY
);

    state_t      state, next_state;
    logic [11:0] ir_q, pc_q;
    logic [11:0] ir_sel, pc_sel;
    logic [11:0] da;
    logic        mri, ind, autoidx;

    logic        mrd_d, mwr_d, done_d, ea_valid_d;
    logic [11:0] maddr_d, mwdata_d, ea_d;

    // In IDLE the live inputs are decoded so the first request can issue on the START edge.
    assign ir_sel = (state == IDLE) ? IR        : ir_q;
    assign pc_sel = (state == IDLE) ? PCLATCHED : pc_q;

    ea_calc #(
        .AUTOIDX_LO (AUTOIDX_LO),
        .AUTOIDX_HI (AUTOIDX_HI)
    ) u_ea_calc (
        .ir      (ir_sel),
        .pc      (pc_sel),
        .da      (da),
        .mri     (mri),
        .ind     (ind),
        .autoidx (autoidx)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            ir_q  <= '0;
            pc_q  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && START) begin
                ir_q <= IR;
                pc_q <= PCLATCHED;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (START) next_state = (mri && ind) ? IRD : FIN;
            IRD:  if (MACK)  next_state = autoidx ? AIW : FIN;
            AIW:  if (MACK)  next_state = FIN;
            FIN:             next_state = IDLE;
            default:         next_state = IDLE;
        endcase
    end

    always_comb begin
        mrd_d      = (next_state == IRD);
        mwr_d      = (next_state == AIW);
        done_d     = (next_state == FIN);
        maddr_d    = MADDR;
        mwdata_d   = MWDATA;
        ea_d       = EA;
        ea_valid_d = EA_VALID;
        if (next_state == IRD || next_state == AIW) maddr_d = da;
        case (state)
            IDLE: begin
                if (START) begin
                    ea_valid_d = 1'b0;
                    if (mri && !ind) begin
                        ea_d       = da;
                        ea_valid_d = 1'b1;
                    end
                end
            end
            IRD: begin
                if (MACK) begin
                    if (autoidx) begin
                        mwdata_d = MRDATA + 12'd1;
                    end else begin
                        ea_d       = MRDATA;
                        ea_valid_d = 1'b1;
                    end
                end
            end
            AIW: begin
                if (MACK) begin
                    ea_d       = MWDATA;
                    ea_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MRD      <= 1'b0;
            MWR      <= 1'b0;
            DONE     <= 1'b0;
            MADDR    <= '0;
            MWDATA   <= '0;
            EA       <= '0;
            EA_VALID <= 1'b0;
        end else begin
            MRD      <= mrd_d;
            MWR      <= mwr_d;
            DONE     <= done_d;
            MADDR    <= maddr_d;
            MWDATA   <= mwdata_d;
            EA       <= ea_d;
            EA_VALID <= ea_valid_d;
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_ea_sequencer.sv
// Directed self-checking bench for ea_sequencer with a wait-state memory model.
module tb_ea_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [11:0] IR = '0;
    logic [11:0] PCLATCHED = '0;
    logic [11:0] MADDR;
    logic        MRD;
    logic        MWR;
    logic [11:0] MWDATA;
    logic [11:0] MRDATA = '0;
    logic        MACK = 1'b0;
    logic [11:0] EA;
    logic        EA_VALID;
    logic        DONE;
    logic        BUSY;

    ea_sequencer dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (START),
        .IR        (IR),
        .PCLATCHED (PCLATCHED),
        .MADDR     (MADDR),
        .MRD       (MRD),
        .MWR       (MWR),
        .MWDATA    (MWDATA),
        .MRDATA    (MRDATA),
        .MACK      (MACK),
        .EA        (EA),
        .EA_VALID  (EA_VALID),
        .DONE      (DONE),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [11:0] mem [0:4095];
    int          rwait = 0, wwait = 0, cnt = 0;
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [11:0] rd_addr = '0, wr_addr = '0, wr_data = '0;

    // Memory model: acknowledges a request after the programmed number of wait cycles.
    always begin
        @(posedge CLK);
        #1;
        if (MRD && MWR) both_cnt++;
        if (MRD || MWR) begin
            if (cnt >= (MRD ? rwait : wwait)) begin
                MACK = 1'b1;
                cnt  = 0;
                if (MRD) begin
                    MRDATA  = mem[MADDR];
                    rd_cnt++;
                    rd_addr = MADDR;
                end else begin
                    mem[MADDR] = MWDATA;
                    wr_cnt++;
                    wr_addr = MADDR;
                    wr_data = MWDATA;
                end
            end else begin
                MACK = 1'b0;
                cnt++;
            end
        end else begin
            MACK = 1'b0;
            cnt  = 0;
        end
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (BUSY && n < 20) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!DONE && lat < 60) begin
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic launch(input logic [11:0] ir, input logic [11:0] pc, output int lat);
        wait_idle();
        clear_mon();
        IR = ir;
        PCLATCHED = pc;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(lat);
    endtask

    int lat;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'o0220] = 12'o3456;
        mem[12'o0010] = 12'o7777;
        mem[12'o0012] = 12'o0100;
        mem[12'o0007] = 12'o1111;
        mem[12'o0017] = 12'o2222;

        #12;
        chk("rst_mrd",      {11'b0, MRD},      12'd0);
        chk("rst_mwr",      {11'b0, MWR},      12'd0);
        chk("rst_done",     {11'b0, DONE},     12'd0);
        chk("rst_busy",     {11'b0, BUSY},     12'd0);
        chk("rst_ea_valid", {11'b0, EA_VALID}, 12'd0);
        chk("rst_ea",       EA,                12'd0);
        chk("rst_maddr",    MADDR,             12'd0);
        chk("rst_mwdata",   MWDATA,            12'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Direct current page: TAD 1234 at 4600
        launch(12'o1234, 12'o4600, lat);
        chk("dir_lat", lat[11:0], 12'd1);
        chk("dir_ea", EA, 12'o4634);
        chk("dir_valid", {11'b0, EA_VALID}, 12'd1);
        chk("dir_rd", rd_cnt[11:0], 12'd0);
        chk("dir_wr", wr_cnt[11:0], 12'd0);

        // Direct page-zero reference inside the auto-index range does not touch memory
        launch(12'o1010, 12'o4600, lat);
        chk("dir0_lat", lat[11:0], 12'd1);
        chk("dir0_ea", EA, 12'o0010);
        chk("dir0_rd", rd_cnt[11:0], 12'd0);

        // Indirect, no auto-index, 2 read waits
        rwait = 2;
        launch(12'o5620, 12'o0200, lat);
        chk("ind_lat", lat[11:0], 12'd4);
        chk("ind_ea", EA, 12'o3456);
        chk("ind_valid", {11'b0, EA_VALID}, 12'd1);
        chk("ind_rd_addr", rd_addr, 12'o0220);
        chk("ind_rd", rd_cnt[11:0], 12'd1);
        chk("ind_wr", wr_cnt[11:0], 12'd0);
        rwait = 0;

        // Indirect through 0007, just below the auto-index range
        launch(12'o1407, 12'o0000, lat);
        chk("below_lat", lat[11:0], 12'd2);
        chk("below_ea", EA, 12'o1111);
        chk("below_wr", wr_cnt[11:0], 12'd0);

        // Auto-index wrap at 0010
        launch(12'o1410, 12'o0000, lat);
        chk("wrap_lat", lat[11:0], 12'd3);
        chk("wrap_rd_addr", rd_addr, 12'o0010);
        chk("wrap_wr_addr", wr_addr, 12'o0010);
        chk("wrap_wr_data", wr_data, 12'o0000);
        chk("wrap_ea", EA, 12'o0000);
        chk("wrap_mem", mem[12'o0010], 12'o0000);

        // Auto-index at upper bound 0017
        launch(12'o1417, 12'o0000, lat);
        chk("top_lat", lat[11:0], 12'd3);
        chk("top_wr_data", wr_data, 12'o2223);
        chk("top_ea", EA, 12'o2223);

        // Current-page auto-index from page 0, 1 read wait and 2 write waits
        rwait = 1;
        wwait = 2;
        launch(12'o1612, 12'o0005, lat);
        chk("cp_lat", lat[11:0], 12'd6);
        chk("cp_rd_addr", rd_addr, 12'o0012);
        chk("cp_wr_addr", wr_addr, 12'o0012);
        chk("cp_wr_data", wr_data, 12'o0101);
        chk("cp_ea", EA, 12'o0101);
        chk("cp_both", both_cnt[11:0], 12'd0);
        rwait = 0;
        wwait = 0;

        // IOT then OPR
        launch(12'o6046, 12'o1000, lat);
        chk("iot_lat", lat[11:0], 12'd1);
        chk("iot_valid", {11'b0, EA_VALID}, 12'd0);
        chk("iot_req", rd_cnt[11:0] + wr_cnt[11:0], 12'd0);
        launch(12'o7200, 12'o1000, lat);
        chk("opr_lat", lat[11:0], 12'd1);
        chk("opr_valid", {11'b0, EA_VALID}, 12'd0);
        chk("opr_req", rd_cnt[11:0] + wr_cnt[11:0], 12'd0);

        // START pulsed while busy is ignored
        rwait = 3;
        wait_idle();
        clear_mon();
        IR = 12'o5620;
        PCLATCHED = 12'o0200;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        IR = 12'o1234;
        PCLATCHED = 12'o4600;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        lat = 2;
        while (!DONE && lat < 60) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk("busy_lat", lat[11:0], 12'd5);
        chk("busy_ea", EA, 12'o3456);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        chk("busy_after_idle", {11'b0, BUSY}, 12'd0);
        chk("busy_after_done", {11'b0, DONE}, 12'd0);
        chk("busy_rd", rd_cnt[11:0], 12'd1);

        // Reset mid-read, then a direct reference
        rwait = 5;
        wait_idle();
        clear_mon();
        IR = 12'o5620;
        PCLATCHED = 12'o0200;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(posedge CLK);
        #1;
        chk("rr_mrd_before", {11'b0, MRD}, 12'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rr_mrd", {11'b0, MRD}, 12'd0);
        chk("rr_mwr", {11'b0, MWR}, 12'd0);
        chk("rr_busy", {11'b0, BUSY}, 12'd0);
        chk("rr_valid", {11'b0, EA_VALID}, 12'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        rwait = 0;
        launch(12'o0177, 12'o4600, lat);
        chk("rr_dir_lat", lat[11:0], 12'd1);
        chk("rr_dir_ea", EA, 12'o0177);
        chk("rr_dir_valid", {11'b0, EA_VALID}, 12'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ea_sequencer.md
# ea_sequencer

Multi-cycle effective-address sequencer for PDP-8 memory-reference instructions (MRIs). It takes the fetched IR and latched PC and resolves the final operand address: page-zero or current-page, direct or indirect, including the auto-index read-modify-write at 0010–0017. It sits after instruction fetch and drives the shared memory port until the address is known. Its direct/indirect and page decisions match the IR decoder's PPIND/IND/DIR/MP classification.

## Interface
Parameters:
- AUTOIDX_LO, 12'o0010, first auto-index location.
- AUTOIDX_HI, 12'o0017, last auto-index location.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request; IR and PCLATCHED are sampled on it.
- IR  in  12  instruction register.
- PCLATCHED  in  12  address of the instruction.
- MADDR  out  12  memory address.
- MRD  out  1  memory read request.
- MWR  out  1  memory write request.
- MWDATA  out  12  write data.
- MRDATA  in  12  read data, valid with MACK.
- MACK  in  1  memory acknowledge.
- EA  out  12  effective address.
- EA_VALID  out  1  EA is meaningful (MRI only); held until the next START.
- DONE  out  1  one-cycle completion pulse.
- BUSY  out  1  high in every state except IDLE.

## Operation
- Opcode is IR[11:9]. MRI means opcode 0–5; IOT is 6 and OPR is 7. IR[8] is the indirect bit. IR[7] selects current page.
- Direct address:
  - IR[7]=1: DA = {PCLATCHED[11:7], IR[6:0]}.
  - IR[7]=0: DA = {5'b0, IR[6:0]}.
- States and transitions:
  - IDLE → on START:
    - IOT/OPR → FIN, EA_VALID=0.
    - MRI with IR[8]=0 → FIN, EA=DA.
    - MRI with IR[8]=1 → IRD.
  - IRD: MADDR=DA, MRD=1. On MACK:
    - DA in [AUTOIDX_LO, AUTOIDX_HI] → capture MRDATA+1 (mod 2^12), go to AIW.
    - Otherwise → EA=MRDATA, go to FIN.
  - AIW: MADDR=DA, MWR=1, MWDATA=captured value. On MACK → EA=captured value, go to FIN.
  - FIN: DONE=1, EA_VALID=1 for MRIs → IDLE.
- Auto-index is decided on the computed DA, not on IR[7]. A current-page reference with PC in page 0 and DA 0010–0017 also auto-indexes.
- JMP and JMS resolve exactly like other MRIs. No special case.
- START while BUSY is ignored; no queuing.
- MRD and MWR are never high together.

## Timing
- Reset values: MRD=0, MWR=0, DONE=0, BUSY=0, EA_VALID=0, EA=0, MADDR=0, MWDATA=0, state IDLE.
- Reset mid-operation aborts at once (asynchronous): MRD and MWR drop with RESET_N low. A half-finished auto-index write is abandoned.
- Memory handshake:
  - MRD/MWR, MADDR and MWDATA are registered.
  - They assert in the cycle after entering IRD/AIW and stay stable until MACK is sampled high.
  - MACK is ignored while no request is high.
  - Zero wait states means MACK is high in the first request cycle.
- Latency, START edge to DONE high:
  - direct MRI / IOT / OPR: 1 cycle.
  - indirect: 2 + read wait states.
  - auto-index: 3 + read waits + write waits.
- EA and EA_VALID update on the same edge that raises DONE.
- Wrap-around: 7777+1 = 0000.

## Structure
- Shared package holds:
  - opcode constants OP_AND…OP_OPR.
  - IR field bit positions (IND_BIT=8, PAGE_BIT=7).
  - the state enum IDLE/IRD/AIW/FIN.
- Auto-index range comes from parameters, not the package.
- One optional sub-module, ea_calc: combinational DA and auto-index-range compare. It reuses the IRDECODER field definitions.

## Test plan
- Direct current page: PCLATCHED=4600, IR=1234 (TAD) → DONE after 1 cycle, EA=4634, EA_VALID=1, MRD and MWR never high.
- Indirect, no auto-index: PCLATCHED=0200, IR=5620, mem[0220]=3456, 2 read wait states → MADDR=0220 during MRD, EA=3456, no MWR, DONE 4 cycles after START.
- Auto-index wrap: IR=1410, mem[0010]=7777 → read 0010, write MWDATA=0000 to 0010, EA=0000.
- Current-page auto-index: PCLATCHED=0005, IR=1612, mem[0012]=0100 → write 0101 to 0012, EA=0101.
- IOT/OPR: IR=6046, then IR=7200 → each gives DONE after 1 cycle, EA_VALID=0, no memory requests. A START pulsed while BUSY is ignored.
- Reset mid-read: RESET_N low while MRD=1 → MRD=0 immediately, BUSY=0, EA_VALID=0. A following direct START completes normally.
